// File: rtl/multicycle_controller_pkg.sv
// Shared control encodings for the multicycle RV32I controller:
// state codes, opcodes, ALU op/control codes and extender select codes.
package multicycle_controller_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;
   localparam logic [3:0] S_TRAP     = 4'd11;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_STORE: imm_src = IMM_S;
         OP_BEQ:   imm_src = IMM_B;
         OP_JAL:   imm_src = IMM_J;
         default:  imm_src = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller uses the master view, the datapath the slave view.
interface multicycle_controller_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       Retire;
   logic       Illegal;

   modport master (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
      output Retire, Illegal
   );

   modport slave (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
      input  Retire, Illegal
   );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to ALUControl.
module multicycle_controller_alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op_b5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // only register-register forms carry a sub bit in funct7
               3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences the shared
// ALU, unified memory and immediate extender over several cycles.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_controller_if.master  bus
);

   logic [3:0] state_q, state_d;
   logic       illegal_q, illegal_d;

   logic [1:0] alu_op;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire;
   logic [1:0] result_src, src_a, src_b;
   logic [2:0] alu_control;

   always_comb begin
      state_d    = state_q;
      alu_op     = ALUOP_ADD;
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      result_src = 2'b00;
      src_a      = 2'b00;
      src_b      = 2'b00;
      case (state_q)
         S_FETCH: begin
            src_b      = 2'b10;
            result_src = 2'b10;
            pc_write   = bus.MemReady;
            ir_write   = bus.MemReady;
            if (bus.MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            src_a = 2'b01;
            src_b = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_JAL:            state_d = S_JAL;
               OP_BEQ:            state_d = S_BEQ;
               default: begin
                  if (TRAP_ON_ILLEGAL) begin
                     state_d = S_TRAP;
                  end else begin
                     state_d = S_FETCH;
                     retire  = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.MemReady) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTER: begin
            src_a   = 2'b10;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            src_a    = 2'b01;
            src_b    = 2'b10;
            pc_write = 1'b1;
            state_d  = S_ALUWB;
         end
         S_BEQ: begin
            src_a    = 2'b10;
            alu_op   = ALUOP_SUB;
            pc_write = bus.Zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   multicycle_controller_alu_decoder u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (bus.funct3),
      .op_b5       (bus.op[5]),
      .funct7b5    (bus.funct7b5),
      .alu_control (alu_control)
   );

   // every output is held quiet for the whole reset cycle
   assign bus.PCWrite    = !reset && pc_write;
   assign bus.AdrSrc     = !reset && adr_src;
   assign bus.MemWrite   = !reset && mem_write;
   assign bus.IRWrite    = !reset && ir_write;
   assign bus.RegWrite   = !reset && reg_write;
   assign bus.Retire     = !reset && retire;
   assign bus.Illegal    = !reset && illegal_q;
   assign bus.ResultSrc  = reset ? 2'b00 : result_src;
   assign bus.ALUSrcA    = reset ? 2'b00 : src_a;
   assign bus.ALUSrcB    = reset ? 2'b00 : src_b;
   assign bus.ALUControl = reset ? 3'b000 : alu_control;
   assign bus.ImmSrc     = reset ? 2'b00 : imm_src(bus.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules are
// generated from the instruction class and checked every cycle.
module tb_multicycle_controller;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] alu;
      logic [1:0] imm;
      logic       ret;
      logic       ill;
   } out_t;

   typedef struct {
      bit   rdy;
      out_t o1;
      out_t o0;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_controller_if b1 ();
   multicycle_controller_if b0 ();

   multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(b1)
   );
   multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .bus(b0)
   );

   out_t a1, a0, exp1, exp0;
   assign a1 = {b1.PCWrite, b1.AdrSrc, b1.MemWrite, b1.IRWrite,
                b1.RegWrite, b1.ResultSrc, b1.ALUSrcA, b1.ALUSrcB,
                b1.ALUControl, b1.ImmSrc, b1.Retire, b1.Illegal};
   assign a0 = {b0.PCWrite, b0.AdrSrc, b0.MemWrite, b0.IRWrite,
                b0.RegWrite, b0.ResultSrc, b0.ALUSrcA, b0.ALUSrcB,
                b0.ALUControl, b0.ImmSrc, b0.Retire, b0.Illegal};

   int    vecs = 0;
   int    errs = 0;
   bit    chk = 1'b0;
   string tag = "idle";
   int    cyc = 0;
   rec_t  q[$];

   always @(negedge clk) begin
      if (chk) begin
         vecs++;
         if (a1 !== exp1) begin
            errs++;
            $display("FAIL %s cyc%0d trap-dut got %b want %b",
                     tag, cyc, a1, exp1);
         end
         vecs++;
         if (a0 !== exp0) begin
            errs++;
            $display("FAIL %s cyc%0d nop-dut got %b want %b",
                     tag, cyc, a0, exp0);
         end
      end
   end

   function automatic out_t base(input logic [1:0] imm);
      out_t o;
      o = '0;
      o.imm = imm;
      return o;
   endfunction

   function automatic void push(input bit rdy, input out_t o1,
                                input out_t o0);
      rec_t r;
      r.rdy = rdy;
      r.o1 = o1;
      r.o0 = o0;
      q.push_back(r);
   endfunction

   function automatic logic [2:0] exec_alu(input logic [2:0] f3,
                                           input logic subbit);
      case (f3)
         3'b000:  return subbit ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected per-cycle outputs for one instruction, from its class.
   function automatic void build(input logic [6:0] op,
                                 input logic [2:0] f3,
                                 input logic f7, input logic zero,
                                 input int fw, input int mw,
                                 input int trail);
      out_t o, o0;
      logic [1:0] imm;
      bit is_mem, is_alu, legal;
      imm = (op == 7'b0100011) ? 2'b01 :
            (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
      is_mem = (op == 7'b0000011) || (op == 7'b0100011);
      is_alu = (op == 7'b0110011) || (op == 7'b0010011);
      legal = is_mem || is_alu || (op == 7'b1101111) ||
              (op == 7'b1100011);
      q.delete();
      o = base(imm);
      o.sb = 2'b10;
      o.rs = 2'b10;
      for (int i = 0; i < fw; i++) push(1'b0, o, o);
      o.pcw = 1'b1;
      o.irw = 1'b1;
      push(1'b1, o, o);
      o = base(imm);
      o.sa = 2'b01;
      o.sb = 2'b01;
      if (!legal) begin
         o0 = o;
         o0.ret = 1'b1;
         push(1'b1, o, o0);
         o = base(imm);
         o.ill = 1'b1;
         o0 = base(imm);
         o0.sb = 2'b10;
         o0.rs = 2'b10;
         for (int i = 0; i < trail; i++) push(1'b0, o, o0);
         return;
      end
      push(1'b1, o, o);
      o = base(imm);
      if (is_mem) begin
         o.sa = 2'b10;
         o.sb = 2'b01;
         push(1'b1, o, o);
         o = base(imm);
         o.adr = 1'b1;
         o.mw = op[5];
         for (int i = 0; i < mw; i++) push(1'b0, o, o);
         o.ret = op[5];
         push(1'b1, o, o);
         if (!op[5]) begin
            o = base(imm);
            o.rs = 2'b01;
            o.rw = 1'b1;
            o.ret = 1'b1;
            push(1'b1, o, o);
         end
      end else if (op == 7'b1100011) begin
         o.sa = 2'b10;
         o.alu = 3'b001;
         o.pcw = zero;
         o.ret = 1'b1;
         push(1'b1, o, o);
      end else begin
         if (is_alu) begin
            o.sa = 2'b10;
            o.sb = op[4] && !op[5] ? 2'b01 : 2'b00;
            o.alu = exec_alu(f3, op[5] & f7);
         end else begin
            o.sa = 2'b01;
            o.sb = 2'b10;
            o.pcw = 1'b1;
         end
         push(1'b1, o, o);
         o = base(imm);
         o.rw = 1'b1;
         o.ret = 1'b1;
         push(1'b1, o, o);
      end
   endfunction

   int lat, mwc, pcwc, illc, ret0;

   task automatic run(input string name, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7,
                      input logic zero, input int fw, input int mw,
                      input int trail, input int stop);
      build(op, f3, f7, zero, fw, mw, trail);
      tag = name;
      lat = 0; mwc = 0; pcwc = 0; illc = 0; ret0 = 0;
      for (int i = 0; i < q.size(); i++) begin
         if (stop > 0 && i >= stop) break;
         @(posedge clk);
         #1;
         reset = 1'b0;
         cyc = i;
         b1.op = op; b0.op = op;
         b1.funct3 = f3; b0.funct3 = f3;
         b1.funct7b5 = f7; b0.funct7b5 = f7;
         b1.Zero = zero; b0.Zero = zero;
         b1.MemReady = q[i].rdy; b0.MemReady = q[i].rdy;
         exp1 = q[i].o1;
         exp0 = q[i].o0;
         chk = 1'b1;
         @(negedge clk);
         if (b1.Retire && lat == 0) lat = i + 1;
         if (b1.MemWrite) mwc++;
         if (b1.PCWrite) pcwc++;
         if (b1.Illegal) illc++;
         if (b0.Retire) ret0++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      tag = "reset";
      cyc = 0;
      b1.MemReady = 1'b0; b0.MemReady = 1'b0;
      exp1 = '0;
      exp0 = '0;
      chk = 1'b1;
      @(negedge clk);
   endtask

   task automatic pin(input string name, input int got, input int want);
      vecs++;
      if (got != want) begin
         errs++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      b1.op = 7'd0; b0.op = 7'd0;
      b1.funct3 = 3'd0; b0.funct3 = 3'd0;
      b1.funct7b5 = 1'b0; b0.funct7b5 = 1'b0;
      b1.Zero = 1'b0; b0.Zero = 1'b0;
      b1.MemReady = 1'b0; b0.MemReady = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 0, 0);
      pin("lw_latency", lat, 5);
      run("sw_wait", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 0, 0);
      pin("sw_latency", lat, 7);
      pin("sw_memwrite_cycles", mwc, 4);
      run("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 0, 0);
      pin("beq_taken_latency", lat, 3);
      pin("beq_taken_pcwrite", pcwc, 2);
      run("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
      pin("beq_not_latency", lat, 3);
      pin("beq_not_pcwrite", pcwc, 1);
      run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 0, 0);
      pin("sub_latency", lat, 4);
      run("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
      run("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, 0, 0);
      run("slt", 7'b0110011, 3'b010, 1'b1, 1'b0, 0, 0, 0, 0);
      run("and", 7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 0, 0);
      run("sll_r", 7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, 0, 0);
      run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 0, 0);
      pin("addi_latency", lat, 4);
      run("ori", 7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 0, 0);
      run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0);
      pin("jal_latency", lat, 4);
      pin("jal_pcwrite", pcwc, 2);
      run("lw_waits", 7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2, 0, 0);
      pin("lw_wait_latency", lat, 9);

      run("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 10, 0);
      pin("trap_no_retire", lat, 0);
      pin("trap_illegal_cycles", illc, 10);
      pin("nop_retire_pulses", ret0, 1);
      do_reset();

      run("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 5, 0, 5);
      do_reset();
      run("lw_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 2, 0, 0, 0);
      pin("lw_after_latency", lat, 7);

      @(posedge clk);
      chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle variant of the RV32I core. It sequences one shared ALU, one unified instruction/data memory and the immediate extender across several cycles per instruction. It drives ImmSrc, the ALU/result mux selects, the write enables and ALUControl. Memory accesses stall on a MemReady handshake. The instruction register, PC and muxes stay in the datapath; this block produces only control.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an unsupported opcode enters TRAP and halts; 0: it is retired as a NOP (DECODE -> FETCH).

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high
op  input  7  Instr[6:0] from instruction register (stable after IRWrite)
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag, current cycle
MemReady  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  0: address = PC, 1: address = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction/OldPC register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J (extender encoding)
Retire  output  1  one-cycle pulse when an instruction completes
Illegal  output  1  sticky; set on entry to TRAP

Behaviour:
- Moore FSM; all outputs except PCWrite, IRWrite, Retire, ImmSrc and ALUControl depend only on state.
- reset=1 at an edge: state <= FETCH and Illegal <= 0. Any in-flight access is abandoned.
- While reset=1, PCWrite, MemWrite, IRWrite, RegWrite and Retire are forced to 0. All other outputs are 0.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCWrite=MemReady. Holds until MemReady=1, then -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; computes the branch/jump target. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> TRAP (or FETCH with Retire=1 if TRAP_ON_ILLEGAL=0)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1, -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until and including the MemReady cycle. Then Retire=1, -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: same but ALUSrcB=01. Both -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1, -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, -> ALUWB (writes PC+4 to rd).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, Retire=1, -> FETCH.
- TRAP: all enables 0, Illegal=1; stays until reset.
- ImmSrc is combinational from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- ALU decoder:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, by funct3: 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; other -> add.
- Retire is asserted only in the cycle the state leaves for FETCH after completing an instruction. TRAP never pulses it.
- Latency with MemReady tied 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.

Decomposition:
- Shared include `riscv_ctrl_defs`: state encodings (4-bit localparams), opcode constants, ALUOp and ALUControl codes, ImmSrc codes (shared with the extender).
- Sub-module `alu_decoder` (combinational: ALUOp, funct3, op[5], funct7b5 -> ALUControl).
- ImmSrc decode stays inline.

Test Plan:
- lw (op=0000011), MemReady=1 -> states F,D,MA,MR,MWB; IRWrite=1 cycle 0; RegWrite=1 with ResultSrc=01 in cycle 4; Retire pulse cycle 4; ImmSrc=00.
- sw (op=0100011), MemReady low 3 cycles in MEMWRITE -> MemWrite high 4 consecutive cycles; AdrSrc=1; ImmSrc=01; Retire on the 4th.
- beq with Zero=1 then Zero=0 -> PCWrite=1 vs 0 in BEQ; ALUControl=001; ImmSrc=10; 3 cycles each.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with funct7b5=1 (op=0010011) -> ALUControl=000.
- jal -> ImmSrc=11, PCWrite=1 in JAL, RegWrite in ALUWB, 4 cycles. op=0000000 -> Illegal=1 and sticky, all enables 0 for 10 cycles. With TRAP_ON_ILLEGAL=0 -> back to FETCH with Retire.
- reset asserted in MEMREAD while MemReady=0 -> next cycle state FETCH, no RegWrite, Illegal cleared; FETCH waits for MemReady.
